// File: rtl/logic_issue.sv
// logic_issue: command-issue and result-capture stage around a combinational
// logic_unit. Commands arrive over a valid/ready handshake and are queued in
// a DEPTH-entry FIFO. One command per cycle moves from the FIFO into a
// registered issue slot that drives the logic_unit operand ports. The
// logic_unit results Y1/Y2 are captured into a result register and returned
// over a second valid/ready handshake. Backpressure propagates end to end.
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   in_valid / in_ready             command handshake (ready = FIFO not full)
//   in_neg, in_select, in_op        command control fields
//   in_a, in_b, in_c, in_d          command operands
//   logic_neg/select/op, A..D       issue-slot fields to logic_unit
//   Y1, Y2                          combinational results from logic_unit
//   res_valid / res_ready           result handshake
//   res_y1, res_y2                  captured results
//   count                           FIFO occupancy, 0..DEPTH
//   busy                            anything held in FIFO, slot or result reg
module logic_issue #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     in_neg,
  input  logic [3:0]               in_select,
  input  logic [2:0]               in_op,
  input  logic [WIDTH-1:0]         in_a,
  input  logic [WIDTH-1:0]         in_b,
  input  logic [WIDTH-1:0]         in_c,
  input  logic [WIDTH-1:0]         in_d,
  output logic                     logic_neg,
  output logic [3:0]               logic_select,
  output logic [2:0]               logic_op,
  output logic [WIDTH-1:0]         A,
  output logic [WIDTH-1:0]         B,
  output logic [WIDTH-1:0]         C,
  output logic [WIDTH-1:0]         D,
  input  logic [WIDTH-1:0]         Y1,
  input  logic [WIDTH-1:0]         Y2,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [WIDTH-1:0]         res_y1,
  output logic [WIDTH-1:0]         res_y2,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     busy
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CMD_W = 8 + 4 * WIDTH;
  localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

  // Command FIFO
  logic [CMD_W-1:0] mem_p0 [DEPTH];
  logic [AW-1:0]    wr_ptr_p0;
  logic [AW-1:0]    rd_ptr_p0;
  logic [AW:0]      count_p0;

  // Issue slot
  logic [CMD_W-1:0] cmd_p1;
  logic             vld_p1;

  // Result register
  logic [WIDTH-1:0] y1_p2;
  logic [WIDTH-1:0] y2_p2;
  logic             vld_p2;

  logic push;
  logic pop;
  logic adv;
  logic capture;
  logic res_free;
  logic fifo_empty;

  assign in_ready   = (count_p0 != FULL);
  assign fifo_empty = (count_p0 == '0);
  assign push       = in_valid && in_ready;
  assign res_free   = !vld_p2 || res_ready;
  // The slot may be refilled when empty or when its current command is
  // being captured this cycle.
  assign adv        = !vld_p1 || res_free;
  assign pop        = adv && !fifo_empty;
  assign capture    = vld_p1 && res_free;

  // ---- stage p0: FIFO storage and occupancy ----
  // Pointer arithmetic wraps naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_p0[wr_ptr_p0] <= {in_neg, in_select, in_op, in_a, in_b, in_c, in_d};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_p0 <= '0;
      rd_ptr_p0 <= '0;
      count_p0  <= '0;
    end else begin
      if (push) wr_ptr_p0 <= wr_ptr_p0 + 1'b1;
      if (pop)  rd_ptr_p0 <= rd_ptr_p0 + 1'b1;
      case ({push, pop})
        2'b10:   count_p0 <= count_p0 + 1'b1;
        2'b01:   count_p0 <= count_p0 - 1'b1;
        default: count_p0 <= count_p0;
      endcase
    end
  end

  // ---- stage p1: issue slot presented to logic_unit ----
  // When the FIFO is empty on an advance only the valid bit clears; the
  // fields keep their last values so logic_unit inputs do not toggle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_p1 <= '0;
      vld_p1 <= 1'b0;
    end else if (adv) begin
      if (pop) begin
        cmd_p1 <= mem_p0[rd_ptr_p0];
        vld_p1 <= 1'b1;
      end else begin
        vld_p1 <= 1'b0;
      end
    end
  end

  // ---- stage p2: result capture ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y1_p2  <= '0;
      y2_p2  <= '0;
      vld_p2 <= 1'b0;
    end else if (capture) begin
      y1_p2  <= Y1;
      y2_p2  <= Y2;
      vld_p2 <= 1'b1;
    end else if (vld_p2 && res_ready) begin
      vld_p2 <= 1'b0;
    end
  end

  assign {logic_neg, logic_select, logic_op, A, B, C, D} = cmd_p1;

  assign res_valid = vld_p2;
  assign res_y1    = y1_p2;
  assign res_y2    = y2_p2;
  assign count     = count_p0;
  assign busy      = !fifo_empty || vld_p1 || vld_p2;

endmodule

// File: doc/logic_issue.md
# logic_issue

Command-issue and result-capture stage wrapped around the combinational `logic_unit`. It accepts logic/arithmetic commands over a valid/ready handshake and queues them in a DEPTH-entry FIFO. It presents one command per cycle from a registered issue slot on the `logic_unit` operand ports, captures `Y1`/`Y2` into a result register and returns them over a second valid/ready handshake. It decouples the register-read front end from the datapath and applies backpressure end to end.

## Interface
- `DEPTH`, 4: command FIFO entries; power of two, ≥2.
- `WIDTH`, 32: operand/result width; must match `logic_unit`.

- `clk` in 1: single clock, all state on rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `in_valid` in 1: command offered.
- `in_ready` out 1: command FIFO not full.
- `in_neg` in 1: command negate flag.
- `in_select` in 4: command select field.
- `in_op` in 3: command opcode.
- `in_a`, `in_b`, `in_c`, `in_d` in WIDTH each: command operands.
- `logic_neg`, `logic_select`, `logic_op` out 1/4/3: issue-slot fields to `logic_unit`.
- `A`, `B`, `C`, `D` out WIDTH each: issue-slot operands to `logic_unit`.
- `Y1`, `Y2` in WIDTH each: combinational results from `logic_unit`.
- `res_valid` out 1: result register holds a result.
- `res_ready` in 1: consumer accepts result.
- `res_y1`, `res_y2` out WIDTH each: captured results.
- `count` out $clog2(DEPTH)+1: FIFO occupancy, 0..DEPTH.
- `busy` out 1: `count`≠0 OR issue slot valid OR `res_valid`.

## Operation
- Three storage levels: FIFO (DEPTH) → issue slot (1) → result register (1). At most DEPTH+2 commands are in flight.
- Push: `in_valid && in_ready` writes the command at the write pointer.
- `in_ready` = (`count` < DEPTH). It depends on FIFO occupancy only. There is no full-FIFO pop bypass.
- Result register free: `res_free` = !`res_valid` || `res_ready`.
- Issue advance (`adv`): the issue slot is empty, or (the slot is valid && `res_free`).
  - On `adv` with FIFO non-empty: pop the head into the issue slot and set the slot valid.
  - On `adv` with FIFO empty: clear the slot valid bit. Slot fields hold their last values.
- Capture: issue slot valid && `res_free` → `res_y1`<=`Y1`, `res_y2`<=`Y2`, `res_valid`<=1.
- Drain: `res_valid && res_ready` with no capture in the same cycle → `res_valid`<=0.
- Push and pop in the same cycle: `count` is unchanged. Both pointers advance modulo DEPTH and wrap naturally.
- Stall: `res_valid` && !`res_ready` means the issue slot, its outputs and `res_y1`/`res_y2` hold exactly. The FIFO keeps accepting until full.
- Ordering: results are returned strictly in acceptance order. No reordering and no drops.
- Opcode values are not interpreted here. Every command yields exactly one result.

## Timing
- Reset (async assert, sync release): `count`=0, pointers=0, issue slot invalid, all `logic_*` outputs and `A`..`D` = 0, `res_valid`=0, `res_y1`=`res_y2`=0, `in_ready`=1, `busy`=0.
- Reset mid-operation discards all queued, issued and captured commands. No result appears after release.
- Latency with an empty pipe and `res_ready`=1:
  - Accept at edge 0.
  - Issue at edge 1: `logic_unit` inputs change after edge 1.
  - Capture at edge 2: `res_valid`=1 after edge 2.
- Throughput: one command per cycle sustained while `res_ready`=1.
- `in_ready` deasserts in the cycle after the edge at which `count` reaches DEPTH.
- `Y1`/`Y2` are sampled in the same cycle the issue slot is presented. `logic_unit` must settle within one period.

## Test plan
- COPY, sel=4'b0001, neg=0, C=0x10, `res_ready`=1 → `res_valid` after edge 2, `res_y1`=16.
- Stream: AND A=0xFF C=0x10, then COPY neg=1 C=0x10 on consecutive cycles → results 16, then 239, on consecutive cycles, in order.
- Backpressure: `res_ready`=0, offer 8 commands with DEPTH=4 → exactly 6 accepted, `count`=4, `in_ready`=0; `res_y1` stable. Release `res_ready` → 6 results in order, then `busy`=0.
- Full with simultaneous push/pop: FIFO at 3, push each cycle with `res_ready`=1 → `count` stays 3; pointers wrap past DEPTH-1 with no data corruption (checked against a scoreboard).
- Reset mid-stream: assert `rst_n`=0 with 4 queued and `res_valid`=1 → all outputs take reset values immediately. After release, no stale result and `in_ready`=1.
- Random valid/ready toggling for 1000 cycles against a reference model of `logic_unit` → zero mismatches and zero lost or duplicated results.
